// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, debug and memory-side signals of the shared instruction-memory port
interface imem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    input  if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, stall, dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_ce, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, stall, dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_ce, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: round-robin sharing of one fixed-latency instruction-memory port between fetch and debug
module imem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst,
  imem_port_arbiter_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_d;
  logic [2:0] cnt;
  logic last_dbg, owner_dbg;
  logic if_win, dbg_win, done;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("imem_port_arbiter: MEM_LAT must be within 1..7");
  end
  // winner selection in IDLE: a lone requester wins, contention goes to whoever did not own the port last
  always_comb begin
    if_win    = state == IDLE && bus.if_req && (!bus.dbg_req || last_dbg);
    dbg_win   = state == IDLE && bus.dbg_req && !if_win;
    done      = state == BUSY && cnt == 3'd1;
    state_d   = (if_win || dbg_win) ? BUSY : done ? IDLE : state;
    win_addr  = dbg_win ? bus.dbg_addr : bus.if_addr;
    win_wdata = dbg_win ? bus.dbg_wdata : '0;
  end
  assign bus.if_gnt  = if_win & rst;
  assign bus.dbg_gnt = dbg_win & rst;
  assign bus.stall   = bus.if_req & ~bus.if_rvalid;
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_d;
  end
  // latch the granted access, count down the memory latency and return data to the owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      last_dbg       <= 1'b1;
      owner_dbg      <= 1'b0;
      bus.mem_ce     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.if_rvalid  <= 1'b0;
      bus.if_rdata   <= '0;
      bus.dbg_rvalid <= 1'b0;
      bus.dbg_rdata  <= '0;
    end else begin
      bus.if_rvalid  <= done && !owner_dbg;
      bus.dbg_rvalid <= done && owner_dbg;
      if (if_win || dbg_win) begin
        bus.mem_ce    <= 1'b1;
        bus.mem_we    <= dbg_win && bus.dbg_we;
        bus.mem_addr  <= win_addr;
        bus.mem_wdata <= win_wdata;
        cnt           <= 3'(MEM_LAT);
        owner_dbg     <= dbg_win;
        last_dbg      <= dbg_win;
      end else if (state == BUSY) begin
        cnt        <= cnt - 3'd1;
        bus.mem_ce <= !done;
        bus.mem_we <= done ? 1'b0 : bus.mem_we;
      end
      if (done && !owner_dbg) bus.if_rdata <= bus.mem_rdata;
      if (done && owner_dbg && !bus.mem_we) bus.dbg_rdata <= bus.mem_rdata;
    end
  end
endmodule
